// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_pkg
//  Description : Shared constants for the bit-serial adder: operand width,
//                FSM state encoding and control/status bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package sumador_pkg;

   // Operand / result width supported at the top level
   localparam int c_WIDTH = 8;

   // FSM state type and encoding
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Control bit positions inside uio_in
   localparam int c_LOAD_A = 0;
   localparam int c_LOAD_B = 1;
   localparam int c_START  = 2;
   localparam int c_CIN    = 3;

   // Status bit positions inside uio_out
   localparam int c_BUSY   = 4;
   localparam int c_DONE   = 5;
   localparam int c_COUT   = 6;
   localparam int c_OVF    = 7;

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : Single-bit combinational full adder used by the serial
//                datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/tt_um_sumador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_sumador_serial
//  Description : Bit-serial adder. Operands are loaded byte-wide, then added
//                LSB first, one bit per enabled clock, through a single
//                full-adder cell and a carry flip-flop. The result, carry-out
//                and signed overflow are registered on completion.
//                Only WIDTH = 8 is legal at this level (fixed-width pins and
//                a 3-bit bit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_sumador_serial
   import sumador_pkg::*;
#(
   parameter int WIDTH = c_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Counter values that mark the last two bit positions
   localparam logic [2:0] c_CNT_MSB_IN = 3'(WIDTH - 2);
   localparam logic [2:0] c_CNT_LAST   = 3'(WIDTH - 1);

   // Control decode
   logic w_load_a;
   logic w_load_b;
   logic w_start;
   logic w_cin;
   logic w_start_edge;
   logic w_unused;

   // State
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_sh_sum;
   logic [2:0]       r_cnt;
   logic             r_carry;
   logic             r_c_msb;
   logic             r_start_q;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_ovf;

   // Full-adder outputs
   logic w_fa_sum;
   logic w_fa_cout;

   assign w_load_a     = uio_in[c_LOAD_A];
   assign w_load_b     = uio_in[c_LOAD_B];
   assign w_start      = uio_in[c_START];
   assign w_cin        = uio_in[c_CIN];
   assign w_start_edge = w_start & ~r_start_q;

   // Upper control nibble carries no function
   assign w_unused = &{1'b0, uio_in[7:4]};

   full_adder_cell u_fa (
      .a    (r_sh_a[0]),
      .b    (r_sh_b[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .cout (w_fa_cout)
   );

   // Start edge detector register, updated in every state while enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_q <= 1'b0;
      end else if (ena) begin
         r_start_q <= w_start;
      end
   end

   // Operand capture; loads are only honoured outside RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else if (ena && (r_state != RUN)) begin
         if (w_load_a) r_a <= ui_in;
         if (w_load_b) r_b <= ui_in;
      end
   end

   // FSM and serial datapath: shift operands, accumulate sum, track carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_sh_sum <= '0;
         r_cnt    <= 3'd0;
         r_carry  <= 1'b0;
         r_c_msb  <= 1'b0;
      end else if (ena) begin
         case (r_state)
            IDLE, DONE: begin
               if (w_start_edge) begin
                  // Operand registers still hold pre-edge values here
                  r_sh_a   <= r_a;
                  r_sh_b   <= r_b;
                  r_sh_sum <= '0;
                  r_carry  <= w_cin;
                  r_cnt    <= 3'd0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_sh_sum <= {w_fa_sum, r_sh_sum[WIDTH-1:1]};
               r_sh_a   <= r_sh_a >> 1;
               r_sh_b   <= r_sh_b >> 1;
               r_carry  <= w_fa_cout;
               r_cnt    <= r_cnt + 3'd1;
               if (r_cnt == c_CNT_MSB_IN) r_c_msb <= w_fa_cout;
               if (r_cnt == c_CNT_LAST)   r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Result registers, written only when the MSB is processed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (ena && (r_state == RUN) && (r_cnt == c_CNT_LAST)) begin
         r_result <= {w_fa_sum, r_sh_sum[WIDTH-1:1]};
         r_cout   <= w_fa_cout;
         r_ovf    <= r_c_msb ^ w_fa_cout;
      end
   end

   assign uo_out  = r_result;
   assign uio_out = {r_ovf, r_cout, (r_state == DONE), (r_state == RUN), 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire

// File: doc/tt_um_sumador_serial.md
TT_UM_SUMADOR_SERIAL -- requirements
Module: tt_um_sumador_serial

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, operand/result width; only 8 is legal at this top level.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port ena  input  1  design enable; low = all state held.
REQ-005 The block SHALL have port ui_in  input  8  operand data byte.
REQ-006 The block SHALL have port uio_in  input  8  controls: [0] load_a, [1] load_b, [2] start, [3] cin, [7:4] unused.
REQ-007 The block SHALL have port uo_out  output  8  registered sum result.
REQ-008 The block SHALL have port uio_out  output  8  status: [4] busy, [5] done, [6] cout, [7] ovf, [3:0] = 0.
REQ-009 The block SHALL drive uio_oe constant 8'hF0.

Function
REQ-010 The block SHALL add A + B + cin bit-serially, LSB first, one bit per cycle, through one full-adder cell and a carry flip-flop.
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-012 In IDLE or DONE, load_a=1 SHALL capture ui_in into A_reg, and load_b=1 SHALL capture it into B_reg, at each clock edge; if both are high, both capture the same byte.
REQ-013 In RUN, load_a and load_b SHALL be ignored.
REQ-014 A start edge SHALL be start=1 sampled with start_q=0; start_q is a register of start updated every enabled cycle in every state.
REQ-015 On a start edge in IDLE or DONE, the block SHALL copy A_reg/B_reg into shift registers, load carry <= cin, clear bit counter, clear done, enter RUN.
REQ-016 When load and start coincide, the operation SHALL use the A_reg/B_reg values held before that edge.
REQ-017 Each RUN cycle SHALL shift the sum bit into the sum shift-register MSB, shift A/B right, update carry, and increment the 3-bit counter.
REQ-018 The carry into bit WIDTH-1 SHALL be captured on the RUN cycle that processes bit WIDTH-2.
REQ-019 On the RUN cycle processing bit WIDTH-1 (counter=7), the block SHALL load uo_out with the full sum, cout with the final carry, and ovf with carry-into-MSB XOR carry-out, and enter DONE.
REQ-020 Latency SHALL be exactly 8 edges from the start-capture edge to done=1/result valid.
REQ-021 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-022 Start edges during RUN SHALL be ignored; no queuing.
REQ-023 uo_out, cout and ovf SHALL hold until the next completion; they SHALL NOT change during RUN.
REQ-024 With ena=0, every register SHALL hold, including start_q.
REQ-025 Arithmetic SHALL be modulo 2^8, with the carry reported only via cout.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE; A_reg, B_reg, shift registers, counter, carry, start_q = 0; uo_out = 0; busy, done, cout, ovf = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no partial result visible; after release, the next start edge SHALL yield a correct result.

Structure
REQ-028 Package sumador_pkg SHALL hold: WIDTH constant, FSM state type (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and control/status bit-index constants.
REQ-029 A combinational sub-module full_adder_cell (a, b, cin -> sum, cout) SHALL be instantiated once.
REQ-030 Unused inputs (uio_in[7:4]) SHALL be explicitly consumed to suppress lint warnings.

Verification
REQ-031 Load A=0x0F, B=0x01, cin=0, start edge -> done exactly 8 cycles later; uo_out=0x10, cout=0, ovf=0.
REQ-032 A=0xFF, B=0x01, cin=0 -> uo_out=0x00, cout=1, ovf=0; A=0xFF, B=0xFF, cin=1 -> uo_out=0xFF, cout=1, ovf=0.
REQ-033 A=0x7F, B=0x01, cin=0 -> uo_out=0x80, cout=0, ovf=1; A=0x80, B=0x80 -> uo_out=0x00, cout=1, ovf=1.
REQ-034 Assert rst_n=0 at RUN cycle 4 -> all outputs 0 and busy=0 immediately; then 0x12+0x34 -> uo_out=0x46.
REQ-035 Hold start=1 for 20 cycles and pulse load_a=0xAA during RUN -> exactly one operation, using the original A; a second start edge in DONE starts a new operation.
REQ-036 Drop ena for 5 cycles mid-RUN -> result unchanged and completion delayed by exactly 5 cycles.
